// File: rtl/euler_pkg.sv
// Shared types for the Euler run sequencer: FSM state encoding, record status
// codes and the width of the cycle counter.
package euler_pkg;

  localparam int CYC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_RUN,
    S_REPORT,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

endpackage

// File: rtl/euler_run_timer.sv
// Per-run cycle counter: cleared on release, counts while a solver runs,
// saturates at all ones and flags the last cycle before timeout.
module euler_run_timer
  import euler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CYC_W-1:0] count_o,
  output logic             last_o
);

  localparam logic [CYC_W-1:0] LAST_CNT = CYC_W'(TIMEOUT_CYCLES - 1);

  logic [CYC_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != '1))
      count_d = count_q + CYC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = en_i && (count_q == LAST_CNT);

endmodule

// File: rtl/euler_run_sequencer.sv
// Sweeps over NUM_SOLVERS solver cores one at a time: releases each from reset,
// waits for done/error/timeout, and hands a result record to the consumer.
module euler_run_sequencer
  import euler_pkg::*;
#(
  parameter int NUM_SOLVERS    = 4,
  parameter int RESULT_W       = 40,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [NUM_SOLVERS-1:0]          solver_rst,
  input  logic [NUM_SOLVERS-1:0]          solver_done,
  input  logic [NUM_SOLVERS-1:0]          solver_error,
  input  logic [NUM_SOLVERS*RESULT_W-1:0] solver_result,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [3:0]                      res_id,
  output logic [1:0]                      res_status,
  output logic [RESULT_W-1:0]             res_data,
  output logic [31:0]                     res_cycles,
  output logic                            all_done
);

  localparam int               IDX_W    = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOLVERS - 1);
  localparam logic [CYC_W-1:0] TMO_CYC  = CYC_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            id_q, id_d;
  status_e               status_q, status_d;
  logic [RESULT_W-1:0]   data_q, data_d;
  logic [CYC_W-1:0]      cycles_q, cycles_d;

  logic [NUM_SOLVERS-1:0][RESULT_W-1:0] result_arr;
  logic                  sel_done, sel_error;
  logic [RESULT_W-1:0]   sel_result;
  logic                  active;
  logic                  tmr_clr, tmr_en, tmr_last;
  logic [CYC_W-1:0]      tmr_count;

  assign result_arr = solver_result;
  assign sel_done   = solver_done[idx_q];
  assign sel_error  = solver_error[idx_q];
  assign sel_result = result_arr[idx_q];

  assign active    = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign tmr_clr   = (state_q == S_RELEASE);
  assign tmr_en    = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_REPORT);
  assign all_done  = (state_q == S_FINISH);

  // Only the selected solver is out of reset, and only while it is running.
  for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_rst
    assign solver_rst[g] = !(active && (idx_q == IDX_W'(g)));
  end

  euler_run_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .count_o (tmr_count),
    .last_o  (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    id_d     = id_q;
    status_d = status_q;
    data_d   = data_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        // Error outranks done, and both outrank the timeout on the last cycle.
        if (sel_error) begin
          status_d = ST_ERR;
          data_d   = sel_result;
          cycles_d = tmr_count;
          state_d  = S_REPORT;
        end else if (sel_done) begin
          status_d = ST_OK;
          data_d   = sel_result;
          cycles_d = tmr_count;
          state_d  = S_REPORT;
        end else if (tmr_last) begin
          status_d = ST_TIMEOUT;
          data_d   = '0;
          cycles_d = TMO_CYC;
          state_d  = S_REPORT;
        end
        if (state_d == S_REPORT) id_d = 4'(idx_q);
      end
      S_REPORT: begin
        if (res_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RELEASE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      id_q     <= '0;
      status_q <= ST_OK;
      data_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      id_q     <= id_d;
      status_q <= status_d;
      data_q   <= data_d;
      cycles_q <= cycles_d;
    end
  end

  assign res_id     = id_q;
  assign res_status = status_q;
  assign res_data   = data_q;
  assign res_cycles = cycles_q;

endmodule

// File: tb/tb_euler_run_sequencer.sv
// Randomized bench for euler_run_sequencer with behavioural solver models and a
// record-level reference model.
module tb_euler_run_sequencer;

  localparam int NS    = 2;
  localparam int RW    = 40;
  localparam int TO    = 50;
  localparam int NEVER = 1_000_000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NS-1:0]        solver_rst;
  logic [NS-1:0]        solver_done;
  logic [NS-1:0]        solver_error;
  logic [NS*RW-1:0]     solver_result;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [3:0]           res_id;
  logic [1:0]           res_status;
  logic [RW-1:0]        res_data;
  logic [31:0]          res_cycles;
  logic                 all_done;

  // Solver i raises done/error once it has been out of reset for more than dd/de cycles.
  int          dd [NS];
  int          de [NS];
  logic [RW-1:0] rv [NS];
  int          age [NS];

  int n_chk  = 0;
  int n_pass = 0;

  euler_run_sequencer #(
    .NUM_SOLVERS    (NS),
    .RESULT_W       (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .solver_rst    (solver_rst),
    .solver_done   (solver_done),
    .solver_error  (solver_error),
    .solver_result (solver_result),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .res_status    (res_status),
    .res_data      (res_data),
    .res_cycles    (res_cycles),
    .all_done      (all_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int i = 0; i < NS; i++) age[i] <= solver_rst[i] ? 0 : age[i] + 1;

  always_comb begin
    solver_done   = '0;
    solver_error  = '0;
    solver_result = '0;
    for (int i = 0; i < NS; i++) begin
      solver_done[i]            = (age[i] >= dd[i] + 1);
      solver_error[i]           = (age[i] >= de[i] + 1);
      solver_result[i*RW +: RW] = rv[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk)
    if (!rst) chk("onehot_rst", 128'($countones(~solver_rst) <= 1), 128'd1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected record for solver i, and k = value of the run counter when it ends.
  function automatic void model(input int i, output logic [1:0] st, output logic [RW-1:0] d,
                                output int cyc, output int k);
    int te, td;
    te = (de[i] < 0) ? 0 : de[i];
    td = (dd[i] < 0) ? 0 : dd[i];
    if (te <= TO - 1 && te <= td) begin
      st = 2'b01; d = rv[i]; cyc = te; k = te;
    end else if (td <= TO - 1) begin
      st = 2'b00; d = rv[i]; cyc = td; k = td;
    end else begin
      st = 2'b10; d = '0; cyc = TO; k = TO - 1;
    end
  endfunction

  // Full sweep; lag<0 picks a random per-record backpressure of 0..4 cycles.
  task automatic sweep(input int lag);
    int n, cyc, k, l;
    logic [1:0] st;
    logic [RW-1:0] d;
    logic [NS-1:0] exp_rst;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < NS; i++) begin
      exp_rst = '1;
      exp_rst[i] = 1'b0;
      chk("release_rst", {busy, solver_rst}, {1'b1, exp_rst});
      model(i, st, d, cyc, k);
      n = 0;
      while (!res_valid && n < TO + 20) begin
        start = ($urandom_range(7) == 0);
        tick();
        n++;
      end
      start = 1'b0;
      chk("latency", n, k + 2);
      l = (lag < 0) ? $urandom_range(4) : lag;
      for (int c = 0; c <= l; c++) begin
        chk("record", {res_valid, res_id, res_status, res_data, res_cycles, solver_rst},
            {1'b1, 4'(i), st, d, 32'(cyc), {NS{1'b1}}});
        if (c < l) tick();
      end
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("valid_drop", res_valid, 0);
    end
    chk("finish", {all_done, busy}, 2'b11);
    start = 1'b1; tick(); start = 1'b0;
    chk("idle", {all_done, busy, res_valid}, 0);
    tick();
    chk("no_restart", {busy, solver_rst}, {1'b0, {NS{1'b1}}});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      dd[i] = NEVER; de[i] = NEVER; rv[i] = '0;
    end
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("reset_state", {solver_rst, busy, res_valid, res_id, res_status, res_data, res_cycles, all_done},
        {{NS{1'b1}}, 81'd0});
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_after_rst", {solver_rst, busy, res_valid, all_done}, {{NS{1'b1}}, 3'd0});

    rv[0] = 40'h5537376230; rv[1] = 40'h1;
    dd[0] = 10; dd[1] = 10;
    sweep(0);

    // Reset in the middle of a run must take effect without waiting for a clock.
    dd[0] = 30;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_midrun", {solver_rst, busy, res_valid, res_id, res_status, res_data, res_cycles, all_done},
        {{NS{1'b1}}, 81'd0});
    tick(); rst = 1'b0;
    repeat (3) tick();
    chk("no_autostart", {busy, solver_rst}, {1'b0, {NS{1'b1}}});
    sweep(0);

    dd[0] = 3; dd[1] = 5; de[1] = 5; rv[1] = 40'hAB_CDEF_0123;
    sweep(1);

    dd[0] = NEVER; dd[1] = 3; de[1] = NEVER;
    sweep(0);

    dd[0] = 49; dd[1] = 50;
    sweep(-1);

    dd[0] = 49; de[0] = 49; dd[1] = NEVER; de[1] = 48;
    sweep(-1);

    dd[0] = -1; de[0] = NEVER; dd[1] = -1; de[1] = NEVER;
    sweep(20);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NS; i++) begin
        rv[i] = RW'({$urandom(), $urandom()});
        case ($urandom_range(3))
          0:       dd[i] = -1;
          3:       dd[i] = NEVER;
          default: dd[i] = $urandom_range(55);
        endcase
        de[i] = ($urandom_range(1) == 0) ? NEVER : int'($urandom_range(55));
      end
      sweep(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
